// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-read-port RAM and its clear sequencer.
// The word merge is written once here so the write path and the read bypass agree on it.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] merge_word(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] data_w,
                                                  input logic [MAX_W-1:0] mask_w);
    return (old_w & ~mask_w) | (data_w & mask_w);
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer: sweeps zeros through every word after reset or a clear request,
// and gates the user write port while the sweep runs.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic                busy_q;
  logic                wr_ready_q;

  // NOTE: all state here is sequential, so every assignment is non-blocking (<=);
  // blocking assignments would make the update order depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      busy_q     <= 1'b1;
      wr_ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          // The pointer wraps to 0 on its own as the last word is cleared.
          if (&clr_ptr_q) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign busy     = busy_q;
  assign wr_ready = wr_ready_q;
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = clr_ptr_q;

endmodule

// File: rtl/ram_mp.sv
// Multi-read-port RAM with one bit-masked write port, a zeroing clear sweep,
// and optional registered reads with write-first bypass.
module ram_mp
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned REG_RD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W-1:0]        wr_mask,
  output logic                     wr_ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int unsigned WORDS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_fire;
  logic [DATA_W-1:0] wr_word_d;

  ram_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_ready (wr_ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_fire   = wr_en & wr_ready;
  assign wr_word_d = DATA_W'(merge_word(MAX_W'(mem_q[wr_addr]), MAX_W'(wr_data), MAX_W'(wr_mask)));

  // NOTE: the array has no reset branch; the clear sweep zeroes it one word per cycle,
  // which keeps it mappable onto RAM macros that cannot be reset in one cycle.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_addr] <= wr_word_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

    if (REG_RD != 0) begin : g_reg
      logic [DATA_W-1:0] rd_d;
      logic [DATA_W-1:0] rd_q;

      // NOTE: rd_d gets a default before the overrides so no path leaves it unassigned,
      // which would otherwise infer a latch.
      always_comb begin
        rd_d = mem_q[addr_k];
        if (clr_we && (clr_addr == addr_k)) begin
          rd_d = '0;
        end else if (wr_fire && (wr_addr == addr_k)) begin
          rd_d = wr_word_d;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_d;
        end
      end

      assign rd_data[k*DATA_W +: DATA_W] = rd_q;
    end else begin : g_comb
      assign rd_data[k*DATA_W +: DATA_W] = mem_q[addr_k];
    end
  end

endmodule

// File: tb/tb_ram_mp.sv
// Self-checking bench for ram_mp: combinational, registered and scaled instances,
// directed vector table, hand-written clear/reset sequences and a random phase against a model.
module tb_ram_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the default-size combinational (c) and registered (r) instances
  logic        rst, wr_en, clr_req;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data, wr_mask;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data_c, rd_data_r;
  logic        busy_c, busy_r, ready_c, ready_r;

  // Scaled instance
  logic         rst_s, wr_en_s, clr_req_s;
  logic [5:0]   wr_addr_s;
  logic [31:0]  wr_data_s, wr_mask_s;
  logic [23:0]  rd_addr_s;
  logic [127:0] rd_data_s;
  logic         busy_s, ready_s;

  ram_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .REG_RD(0)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_ready(ready_c), .rd_addr(rd_addr), .rd_data(rd_data_c),
    .clr_req(clr_req), .busy(busy_c)
  );

  ram_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .REG_RD(1)) dut_r (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_ready(ready_r), .rd_addr(rd_addr), .rd_data(rd_data_r),
    .clr_req(clr_req), .busy(busy_r)
  );

  ram_mp #(.DATA_W(32), .ADDR_W(6), .NUM_RD(4), .REG_RD(0)) dut_s (
    .clk(clk), .rst(rst_s), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .wr_mask(wr_mask_s), .wr_ready(ready_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .clr_req(clr_req_s), .busy(busy_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: word array plus a count of sweep cycles still to run
  logic [15:0] mem_m [16];
  int          clr_left;
  int          clr_pos;
  logic [15:0] exp_rq0, exp_rq1;

  task automatic model_edge();
    logic [3:0]  a0, a1;
    logic [15:0] nw;
    a0 = rd_addr[3:0];
    a1 = rd_addr[7:4];
    if (rst) begin
      clr_left = 16;
      clr_pos  = 0;
      exp_rq0  = '0;
      exp_rq1  = '0;
    end else if (clr_left > 0) begin
      exp_rq0 = (int'(a0) == clr_pos) ? 16'h0 : mem_m[a0];
      exp_rq1 = (int'(a1) == clr_pos) ? 16'h0 : mem_m[a1];
      mem_m[clr_pos] = '0;
      clr_pos  = (clr_pos + 1) % 16;
      clr_left = clr_left - 1;
    end else begin
      nw = (mem_m[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
      exp_rq0 = (wr_en && wr_addr == a0) ? nw : mem_m[a0];
      exp_rq1 = (wr_en && wr_addr == a1) ? nw : mem_m[a1];
      if (wr_en) mem_m[wr_addr] = nw;
      if (clr_req) begin
        clr_left = 16;
        clr_pos  = 0;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [15:0] wm;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [15:0] c0;  // combinational read before the edge
    logic [15:0] c1;
    logic [15:0] r0;  // registered read after the edge
    logic [15:0] r1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd3,  16'hFFFF, 16'hFFFF, 4'd3,  4'd3,  16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[1] = '{1'b1, 4'd3,  16'h1234, 16'h00FF, 4'd3,  4'd0,  16'hFFFF, 16'h0000, 16'hFF34, 16'h0000};
    vecs[2] = '{1'b0, 4'd0,  16'h0000, 16'h0000, 4'd3,  4'd3,  16'hFF34, 16'hFF34, 16'hFF34, 16'hFF34};
    vecs[3] = '{1'b1, 4'd5,  16'hBEEF, 16'hFFFF, 4'd5,  4'd3,  16'h0000, 16'hFF34, 16'hBEEF, 16'hFF34};
    vecs[4] = '{1'b1, 4'd5,  16'h0000, 16'hF0F0, 4'd5,  4'd5,  16'hBEEF, 16'hBEEF, 16'h0E0F, 16'h0E0F};
    vecs[5] = '{1'b1, 4'd15, 16'hABCD, 16'h0000, 4'd15, 4'd5,  16'h0000, 16'h0E0F, 16'h0000, 16'h0E0F};
    vecs[6] = '{1'b1, 4'd0,  16'hFFFF, 16'h8001, 4'd0,  4'd15, 16'h0000, 16'h0000, 16'h8001, 16'h0000};
    vecs[7] = '{1'b0, 4'd0,  16'h0000, 16'h0000, 4'd0,  4'd3,  16'h8001, 16'hFF34, 16'h8001, 16'hFF34};

    rst = 1'b1; wr_en = 1'b0; clr_req = 1'b0;
    wr_addr = '0; wr_data = '0; wr_mask = '0; rd_addr = '0;
    rst_s = 1'b1; wr_en_s = 1'b0; clr_req_s = 1'b0;
    wr_addr_s = '0; wr_data_s = '0; wr_mask_s = '0; rd_addr_s = '0;

    // Reset sweep
    tick();
    tick();
    check("rst_busy", 64'(busy_c), 64'(1));
    check("rst_ready", 64'(ready_c), 64'(0));
    check("rst_rdreg", 64'(rd_data_r), 64'(0));
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("sweep_busy_c[%0d]", i), 64'(busy_c), 64'(i < 16));
      check($sformatf("sweep_ready_c[%0d]", i), 64'(ready_c), 64'(i >= 16));
      check($sformatf("sweep_busy_r[%0d]", i), 64'(busy_r), 64'(i < 16));
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = {4'(a), 4'(15 - a)};
      #1;
      check($sformatf("zero_c[%0d]", a), 64'(rd_data_c), 64'(0));
      tick();
      check($sformatf("zero_r[%0d]", a), 64'(rd_data_r), 64'(0));
    end

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      wr_en   = vecs[v].we;
      wr_addr = vecs[v].wa;
      wr_data = vecs[v].wd;
      wr_mask = vecs[v].wm;
      rd_addr = {vecs[v].ra1, vecs[v].ra0};
      #1;
      check($sformatf("vec%0d_c0", v), 64'(rd_data_c[15:0]),  64'(vecs[v].c0));
      check($sformatf("vec%0d_c1", v), 64'(rd_data_c[31:16]), 64'(vecs[v].c1));
      tick();
      check($sformatf("vec%0d_r0", v), 64'(rd_data_r[15:0]),  64'(vecs[v].r0));
      check($sformatf("vec%0d_r1", v), 64'(rd_data_r[31:16]), 64'(vecs[v].r1));
    end
    wr_en = 1'b0;

    // Clear request with a same-cycle write, then writes while busy
    for (int a = 0; a < 16; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = 16'hA5A5; wr_mask = 16'hFFFF;
      tick();
    end
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1111; wr_mask = 16'hFFFF;
    clr_req = 1'b1; rd_addr = {4'd7, 4'd7};
    #1;
    check("fill_a7", 64'(rd_data_c[15:0]), 64'(16'hA5A5));
    tick();
    clr_req = 1'b0;
    check("clr_busy_rise", 64'(busy_c), 64'(1));
    check("clr_ready_low", 64'(ready_c), 64'(0));
    check("clr_same_cycle_wr", 64'(rd_data_c[15:0]), 64'(16'h1111));
    for (int i = 1; i <= 16; i++) begin
      wr_en = (i >= 5); wr_addr = 4'd2; wr_data = 16'hFFFF; wr_mask = 16'hFFFF;
      tick();
      check($sformatf("clr_busy[%0d]", i), 64'(busy_c), 64'(i < 16));
    end
    wr_en = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd_addr = {4'(a), 4'(a)};
      #1;
      check($sformatf("clr_zero_c[%0d]", a), 64'(rd_data_c), 64'(0));
      tick();
      check($sformatf("clr_zero_r[%0d]", a), 64'(rd_data_r), 64'(0));
    end

    // Reset in the middle of a sweep restarts it
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("midrst_busy[%0d]", i), 64'(busy_c), 64'(i < 16));
    end

    // Random phase against the reference model
    for (int a = 0; a < 16; a++) mem_m[a] = '0;
    clr_left = 0;
    clr_pos  = 0;
    for (int i = 0; i < 400; i++) begin
      wr_en   = 1'($urandom);
      wr_addr = 4'($urandom);
      wr_data = 16'($urandom);
      wr_mask = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
      clr_req = ($urandom_range(0, 39) == 0);
      rd_addr = 8'($urandom);
      #1;
      check("rnd_c0", 64'(rd_data_c[15:0]),  64'(mem_m[rd_addr[3:0]]));
      check("rnd_c1", 64'(rd_data_c[31:16]), 64'(mem_m[rd_addr[7:4]]));
      model_edge();
      tick();
      check("rnd_busy", 64'(busy_c), 64'(clr_left > 0));
      check("rnd_ready", 64'(ready_r), 64'(clr_left == 0));
      check("rnd_r0", 64'(rd_data_r[15:0]),  64'(exp_rq0));
      check("rnd_r1", 64'(rd_data_r[31:16]), 64'(exp_rq1));
    end
    wr_en = 1'b0; clr_req = 1'b0;

    // Scaled configuration
    tick();
    check("s_rst_busy", 64'(busy_s), 64'(1));
    rst_s = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      check($sformatf("s_busy[%0d]", i), 64'(busy_s), 64'(i < 64));
    end
    wr_en_s = 1'b1; wr_addr_s = 6'd63; wr_data_s = 32'hDEADBEEF; wr_mask_s = 32'hFFFFFFFF;
    rd_addr_s = {4{6'd63}};
    tick();
    wr_en_s = 1'b1; wr_addr_s = 6'd0; wr_data_s = 32'h12345678; wr_mask_s = 32'hFFFF0000;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s_rd63[%0d]", k), 64'(rd_data_s[k*32 +: 32]), 64'(32'hDEADBEEF));
    end
    tick();
    wr_en_s = 1'b0;
    rd_addr_s = {6'd63, 6'd0, 6'd63, 6'd1};
    #1;
    check("s_mask_a0", 64'(rd_data_s[95:64]), 64'(32'h12340000));
    check("s_a1_zero", 64'(rd_data_s[31:0]), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_mp.md
Name: ram_mp

Overview:
- Parametrised multi-read-port RAM with one masked write port and a built-in clear sequencer.
- Successor to the fixed 16x16 two-read-port RAM in the datapath.
- Generalises data width, depth and read-port count; adds optional registered reads with write-first bypass.
- Reset or a clear request zeroes every word; a busy flag blocks writes while the clear runs.

Parameters:
- DATA_W, 16: word width in bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2: number of independent read ports (1..8).
- REG_RD, 0: 0 = combinational read; 1 = read data registered, one-cycle latency.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_mask  in  DATA_W  per-bit write enable; 1 = bit updated.
- wr_ready  out  1  write accepted this cycle (high only in IDLE).
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
- clr_req  in  1  single-cycle pulse; starts a full clear.
- busy  out  1  clear in progress.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- While rst is high:
  - state = CLEAR, clr_ptr = 0.
  - busy = 1, wr_ready = 0.
  - If REG_RD=1, all rd_data registers = 0.
  - Array contents are not touched by rst itself; the clear sweep zeroes them.
- State CLEAR:
  - Each cycle writes 0 to word clr_ptr, then clr_ptr increments.
  - After the cycle with clr_ptr = DEPTH-1, the next state is IDLE.
  - Exactly DEPTH cycles after rst deasserts, busy goes 0.
  - clr_ptr wraps naturally at ADDR_W bits; there is no separate terminal counter.
- State IDLE:
  - busy = 0, wr_ready = 1.
  - If wr_en=1, mem[wr_addr] = (mem & ~wr_mask) | (wr_data & wr_mask) at the clock edge.
  - If clr_req=1, the next state is CLEAR with clr_ptr = 0.
  - A write in the same cycle as clr_req is still performed; the sweep clears it later.
- clr_req while in CLEAR: ignored; the sweep does not restart.
- rst asserted mid-clear: the sweep restarts at address 0.
- wr_en while busy: dropped (wr_ready=0); no queuing.
- Reads are always served, including during CLEAR, and return current array contents (partially cleared words are visible).
- REG_RD=0:
  - rd_data[k] = mem[rd_addr[k]] combinationally.
  - A same-cycle write to that address shows the old value until the edge.
- REG_RD=1:
  - rd_data[k] is registered.
  - Write-first bypass: if wr_en & wr_ready and wr_addr == rd_addr[k], the register captures the merged new word, not the old one.
  - During CLEAR, a read of clr_ptr captures 0.
- Multiple read ports may address the same word; every port receives the same value.
- There are no X outputs after reset, for any port.

Decomposition:
- Package ram_pkg:
  - state enum {CLEAR, IDLE}.
  - Function merge_word(old, data, mask).
  - Localparam DEPTH derived from ADDR_W.
- One sub-module, ram_clear_fsm:
  - Owns the state, clr_ptr, busy and wr_ready.
  - Emits the internal signals clr_we and clr_addr.
- The top level holds the array, write mux (clear has priority), read ports and bypass logic.

Test Plan:
1. Reset sweep: default params, rst high 2 cycles then low -> busy stays 1 for exactly 16 cycles then 0; all 16 words read 0x0000 on both ports.
2. Masked write: IDLE, write 0xFFFF to addr 3, then wr_data=0x1234 with wr_mask=0x00FF to addr 3 -> read addr 3 = 0xFF34 on port 0 and port 1.
3. Bypass: REG_RD=1, write 0xBEEF to addr 5 with rd_addr[0]=5 in the same cycle -> rd_data[0]=0xBEEF on the next cycle. With REG_RD=0 the same stimulus shows the old value 0x0000 in that cycle.
4. Clear request: fill addr 0..15 with 0xA5A5, pulse clr_req with a write of 0x1111 to addr 7 in the same cycle.
   - busy rises next cycle; wr_en during busy is dropped.
   - After 16 cycles busy=0 and every word, including addr 7, reads 0x0000.
5. Reset mid-clear: pulse clr_req, assert rst at sweep cycle 9 -> sweep restarts at 0; busy remains 1 for 16 cycles after rst falls.
6. Scaled config: DATA_W=32, ADDR_W=6, NUM_RD=4 -> busy lasts 64 cycles; writing 0xDEADBEEF to addr 63 is read back identically on all four ports simultaneously.
